// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, display enable, pixel/block coordinates, line/frame strobes.
// Optional 16-bit frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int DIV_X    = 4,
  parameter int DIV_Y    = 4,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [HW-1:0] o_x,
  output logic [VW-1:0] o_y,
  output logic [HW-1:0] o_bx,
  output logic [VW-1:0] o_by,
  output logic          o_blk_new,
  output logic          o_line_start,
  output logic          o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   o_frame_cnt
`endif
);

  // state    | meaning
  // PH_SYNC  | sync pulse asserted
  // PH_BACK  | back porch (skipped when zero length)
  // PH_ACT   | visible pixels / lines
  // PH_FRONT | front porch (skipped when zero length)
  localparam logic [1:0] PH_SYNC  = 2'd0;
  localparam logic [1:0] PH_BACK  = 2'd1;
  localparam logic [1:0] PH_ACT   = 2'd2;
  localparam logic [1:0] PH_FRONT = 2'd3;

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  logic [1:0]    h_phase, v_phase, h_nxt, v_nxt;
  logic          h_end, v_end, h_wrap, h_act, v_act;
  logic [HW-1:0] h_cnt, h_sub, bx_cnt;
  logic [VW-1:0] v_cnt, v_sub, by_cnt;
  logic [3:0]    bx_sub, by_sub;

  assign h_wrap = (h_cnt == HW'(H_TOTAL - 1));
  assign h_act  = (h_phase == PH_ACT);
  assign v_act  = (v_phase == PH_ACT);

  always_comb begin
    h_end = 1'b0;
    h_nxt = h_phase;
    case (h_phase)
      PH_SYNC: begin
        h_end = (h_sub == HW'(H_SYNC - 1));
        h_nxt = (H_BACK > 0) ? PH_BACK : PH_ACT;
      end
      PH_BACK: begin
        h_end = (h_sub == HW'(H_BACK - 1));
        h_nxt = PH_ACT;
      end
      PH_ACT: begin
        h_end = (h_sub == HW'(H_ACTIVE - 1));
        h_nxt = (H_FRONT > 0) ? PH_FRONT : PH_SYNC;
      end
      default: begin
        h_end = (h_sub == HW'(H_FRONT - 1));
        h_nxt = PH_SYNC;
      end
    endcase
  end

  always_comb begin
    v_end = 1'b0;
    v_nxt = v_phase;
    case (v_phase)
      PH_SYNC: begin
        v_end = (v_sub == VW'(V_SYNC - 1));
        v_nxt = (V_BACK > 0) ? PH_BACK : PH_ACT;
      end
      PH_BACK: begin
        v_end = (v_sub == VW'(V_BACK - 1));
        v_nxt = PH_ACT;
      end
      PH_ACT: begin
        v_end = (v_sub == VW'(V_ACTIVE - 1));
        v_nxt = (V_FRONT > 0) ? PH_FRONT : PH_SYNC;
      end
      default: begin
        v_end = (v_sub == VW'(V_FRONT - 1));
        v_nxt = PH_SYNC;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt   <= '0;
      h_sub   <= '0;
      h_phase <= PH_SYNC;
      bx_sub  <= '0;
      bx_cnt  <= '0;
      v_cnt   <= '0;
      v_sub   <= '0;
      v_phase <= PH_SYNC;
      by_sub  <= '0;
      by_cnt  <= '0;
    end else if (i_en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_end) begin
        h_phase <= h_nxt;
        h_sub   <= '0;
      end else begin
        h_sub <= h_sub + 1'b1;
      end
      // block sub-counters sit at zero outside active so each active span starts a fresh block
      if (h_act) begin
        if (bx_sub == 4'(DIV_X - 1)) begin
          bx_sub <= '0;
          bx_cnt <= bx_cnt + 1'b1;
        end else begin
          bx_sub <= bx_sub + 1'b1;
        end
      end else begin
        bx_sub <= '0;
        bx_cnt <= '0;
      end
      if (h_wrap) begin
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        if (v_end) begin
          v_phase <= v_nxt;
          v_sub   <= '0;
        end else begin
          v_sub <= v_sub + 1'b1;
        end
        if (v_act) begin
          if (by_sub == 4'(DIV_Y - 1)) begin
            by_sub <= '0;
            by_cnt <= by_cnt + 1'b1;
          end else begin
            by_sub <= by_sub + 1'b1;
          end
        end else begin
          by_sub <= '0;
          by_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_hsync       <= ~H_POL;
      o_vsync       <= ~V_POL;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_bx          <= '0;
      o_by          <= '0;
      o_blk_new     <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_en) begin
      o_hsync       <= (h_phase == PH_SYNC) ? H_POL : ~H_POL;
      o_vsync       <= (v_phase == PH_SYNC) ? V_POL : ~V_POL;
      o_de          <= h_act && v_act;
      o_x           <= h_act ? h_sub : '0;
      o_bx          <= h_act ? bx_cnt : '0;
      o_y           <= v_act ? v_sub : '0;
      o_by          <= v_act ? by_cnt : '0;
      o_blk_new     <= h_act && v_act && (bx_sub == '0);
      o_line_start  <= (h_cnt == '0);
      o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      o_blk_new     <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic seen_first;

  // the frame start right after reset is frame zero, so only later starts count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_frame_cnt <= '0;
      seen_first  <= 1'b0;
    end else if (i_en && (h_cnt == '0) && (v_cnt == '0)) begin
      if (seen_first) o_frame_cnt <= o_frame_cnt + 1'b1;
      seen_first <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against a raster-position model.
// Frame counter checks are included when VGA_TIMING_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

  localparam int AHS = 3, AHB = 0, AHA = 10, AHF = 2, AVS = 2, AVB = 1, AVA = 6, AVF = 1;
  localparam int ADX = 3, ADY = 4, AHW = 5, AVW = 4;
  localparam int BHS = 2, BHB = 3, BHA = 8, BHF = 0, BVS = 1, BVB = 0, BVA = 5, BVF = 2;
  localparam int BDX = 1, BDY = 2, BHW = 4, BVW = 3;

  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf, dx, dy;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    bit hsync, vsync, de, bn, ls, fs;
    int x, y, bx, by, fc;
  } exp_t;

  logic clk, rst_n, en;
  int   errors = 0, checks = 0;
  int   n_de, n_hs, n_vs, n_fs, k_first;

  cfg_t cfg[3];
  exp_t ex[3];
  int   hc[3], vc[3];
  bit   seen[3];

  logic a_hs, a_vs, a_de, a_bn, a_ls, a_fs;
  logic [AHW-1:0] a_x, a_bx;
  logic [AVW-1:0] a_y, a_by;
  logic b_hs, b_vs, b_de, b_bn, b_ls, b_fs;
  logic [BHW-1:0] b_x, b_bx;
  logic [BVW-1:0] b_y, b_by;
  logic d_hs, d_vs, d_de, d_bn, d_ls, d_fs;
  logic [10:0] d_x, d_bx;
  logic [9:0]  d_y, d_by;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc, d_fc;
`endif

  vga_timing_gen #(.H_ACTIVE(AHA), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
    .V_ACTIVE(AVA), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB), .H_POL(1'b1), .V_POL(1'b1),
    .DIV_X(ADX), .DIV_Y(ADY), .HW(AHW), .VW(AVW)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
    .o_x(a_x), .o_y(a_y), .o_bx(a_bx), .o_by(a_by), .o_blk_new(a_bn),
    .o_line_start(a_ls), .o_frame_start(a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(a_fc)
`endif
  );

  vga_timing_gen #(.H_ACTIVE(BHA), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_ACTIVE(BVA), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB), .H_POL(1'b0), .V_POL(1'b0),
    .DIV_X(BDX), .DIV_Y(BDY), .HW(BHW), .VW(BVW)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
    .o_x(b_x), .o_y(b_y), .o_bx(b_bx), .o_by(b_by), .o_blk_new(b_bn),
    .o_line_start(b_ls), .o_frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(b_fc)
`endif
  );

  vga_timing_gen u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de),
    .o_x(d_x), .o_y(d_y), .o_bx(d_bx), .o_by(d_by), .o_blk_new(d_bn),
    .o_line_start(d_ls), .o_frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(d_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%0d expected=%0d", tag, i, obs, expv);
    end
  endtask

  // Expected outputs follow from the raster position alone: phase boundaries by arithmetic.
  task automatic model_step(input bit r, input bit e);
    for (int i = 0; i < 3; i++) begin
      int ht, vt, h0, v0;
      bit hact, vact;
      ht = cfg[i].hs + cfg[i].hb + cfg[i].ha + cfg[i].hf;
      vt = cfg[i].vs + cfg[i].vb + cfg[i].va + cfg[i].vf;
      h0 = cfg[i].hs + cfg[i].hb;
      v0 = cfg[i].vs + cfg[i].vb;
      if (!r) begin
        hc[i] = 0; vc[i] = 0; seen[i] = 1'b0;
        ex[i] = '{hsync: !cfg[i].hp, vsync: !cfg[i].vp, de: 0, bn: 0, ls: 0, fs: 0,
                  x: 0, y: 0, bx: 0, by: 0, fc: 0};
      end else if (e) begin
        hact = (hc[i] >= h0) && (hc[i] < h0 + cfg[i].ha);
        vact = (vc[i] >= v0) && (vc[i] < v0 + cfg[i].va);
        ex[i].x = hact ? hc[i] - h0 : 0;
        ex[i].y = vact ? vc[i] - v0 : 0;
        ex[i].bx = ex[i].x / cfg[i].dx;
        ex[i].by = ex[i].y / cfg[i].dy;
        ex[i].de = hact && vact;
        ex[i].bn = ex[i].de && (ex[i].x % cfg[i].dx == 0);
        ex[i].hsync = (hc[i] < cfg[i].hs) ? cfg[i].hp : !cfg[i].hp;
        ex[i].vsync = (vc[i] < cfg[i].vs) ? cfg[i].vp : !cfg[i].vp;
        ex[i].ls = (hc[i] == 0);
        ex[i].fs = (hc[i] == 0) && (vc[i] == 0);
        if (ex[i].fs) begin
          if (seen[i]) ex[i].fc = (ex[i].fc + 1) % 65536;
          seen[i] = 1'b1;
        end
        hc[i]++;
        if (hc[i] == ht) begin
          hc[i] = 0;
          vc[i]++;
          if (vc[i] == vt) vc[i] = 0;
        end
      end else begin
        ex[i].ls = 1'b0; ex[i].fs = 1'b0; ex[i].bn = 1'b0;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic hs, vs, de, bn, ls, fs,
                            input logic [31:0] x, y, bx, by);
    cmp("hsync", i, 32'(hs), 32'(ex[i].hsync));
    cmp("vsync", i, 32'(vs), 32'(ex[i].vsync));
    cmp("de", i, 32'(de), 32'(ex[i].de));
    cmp("x", i, x, 32'(ex[i].x));
    cmp("y", i, y, 32'(ex[i].y));
    cmp("bx", i, bx, 32'(ex[i].bx));
    cmp("by", i, by, 32'(ex[i].by));
    cmp("blk_new", i, 32'(bn), 32'(ex[i].bn));
    cmp("line_start", i, 32'(ls), 32'(ex[i].ls));
    cmp("frame_start", i, 32'(fs), 32'(ex[i].fs));
  endtask

  task automatic tick(input bit r, input bit e);
    rst_n = r;
    en    = e;
    @(posedge clk);
    model_step(r, e);
    @(negedge clk);
    check_inst(0, a_hs, a_vs, a_de, a_bn, a_ls, a_fs, 32'(a_x), 32'(a_y), 32'(a_bx), 32'(a_by));
    check_inst(1, b_hs, b_vs, b_de, b_bn, b_ls, b_fs, 32'(b_x), 32'(b_y), 32'(b_bx), 32'(b_by));
    check_inst(2, d_hs, d_vs, d_de, d_bn, d_ls, d_fs, 32'(d_x), 32'(d_y), 32'(d_bx), 32'(d_by));
`ifdef VGA_TIMING_FRAME_CNT_EN
    cmp("frame_cnt", 0, 32'(a_fc), 32'(ex[0].fc));
    cmp("frame_cnt", 1, 32'(b_fc), 32'(ex[1].fc));
    cmp("frame_cnt", 2, 32'(d_fc), 32'(ex[2].fc));
`endif
  endtask

  initial begin
    cfg[0] = '{hs: AHS, hb: AHB, ha: AHA, hf: AHF, vs: AVS, vb: AVB, va: AVA, vf: AVF,
               dx: ADX, dy: ADY, hp: 1'b1, vp: 1'b1};
    cfg[1] = '{hs: BHS, hb: BHB, ha: BHA, hf: BHF, vs: BVS, vb: BVB, va: BVA, vf: BVF,
               dx: BDX, dy: BDY, hp: 1'b0, vp: 1'b0};
    cfg[2] = '{hs: 128, hb: 88, ha: 800, hf: 40, vs: 4, vb: 23, va: 600, vf: 1,
               dx: 4, dy: 4, hp: 1'b1, vp: 1'b1};
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);

    // reset values, then one full frame of config A with a steady tick
    repeat (3) tick(1'b0, 1'b1);
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    for (int k = 0; k < 150; k++) begin
      tick(1'b1, 1'b1);
      n_de += int'(a_de); n_hs += int'(a_hs); n_vs += int'(a_vs); n_fs += int'(a_fs);
    end
    cmp("frame_de_count", 0, 32'(n_de), 32'(AHA * AVA));
    cmp("frame_hsync_count", 0, 32'(n_hs), 32'(AHS * 10));
    cmp("frame_vsync_count", 0, 32'(n_vs), 32'(AVS * 15));
    cmp("frame_start_count", 0, 32'(n_fs), 32'd1);

    // random pixel ticks with occasional resets
    for (int k = 0; k < 3000; k++)
      tick($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);

    // alternating tick, then a one-cycle reset mid-frame and recovery
    for (int k = 0; k < 400; k++) tick(1'b1, k[0] == 1'b0);
    repeat (37) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    cmp("reset_de", 0, 32'(a_de), 32'd0);
    tick(1'b1, 1'b1);
    cmp("restart_frame_start", 0, 32'(a_fs), 32'd1);

    // several frames for the small configs and the first visible pixel at default timing
    repeat (2) tick(1'b0, 1'b1);
    k_first = 0;
    for (int k = 1; k <= 30000; k++) begin
      tick(1'b1, 1'b1);
      if (d_de && k_first == 0) k_first = k;
    end
    cmp("default_first_de_tick", 2, 32'(k_first), 32'(27 * 1056 + 216 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
